// File: rtl/celik_lab2_sys_seg_bank.sv
// celik_lab2_sys_seg_bank: Avalon-MM slave driving a bank of seven-segment digits.
// Holds one 8-bit register per digit plus CTRL (HEX/BLINK/INV), MASK and DIV.
// Per-digit blinking is timed by a DIV-reloaded down-counter; the final
// pattern is registered into out_port every cycle.
//
// Optional feature: define SEG_BANK_HEX_DECODE_EN to build the hex-nibble
// decoder and CTRL.HEX. Without it CTRL bit0 is write-ignored / reads 0.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   address, chipselect,     Avalon-MM word address and write strobe
//   write_n, writedata
//   readdata                 combinational read data, zero wait states
//   out_port                 segment outputs, digit n at [8n+7:8n] (dp,g..a)
module celik_lab2_sys_seg_bank #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned DIV_W      = 24
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] out_port
);

  localparam logic [ADDR_W-1:0] AddrCtrl = ADDR_W'(NUM_DIGITS);
  localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(NUM_DIGITS + 1);
  localparam logic [ADDR_W-1:0] AddrDiv  = ADDR_W'(NUM_DIGITS + 2);

  logic                    wr_en;
  logic [7:0]              digit_q [NUM_DIGITS];
  logic                    blink_q;
  logic                    inv_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [DIV_W-1:0]        div_q;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic [8*NUM_DIGITS-1:0] out_q, out_d;

`ifdef SEG_BANK_HEX_DECODE_EN
  logic hex_q;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    unique case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction
`endif

  assign wr_en = chipselect & ~write_n;

  // Register file
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NUM_DIGITS; n++) digit_q[n] <= '0;
      blink_q <= 1'b0;
      inv_q   <= 1'b0;
`ifdef SEG_BANK_HEX_DECODE_EN
      hex_q   <= 1'b0;
`endif
      mask_q  <= '0;
      div_q   <= '0;
    end else if (wr_en) begin
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (address == ADDR_W'(n)) digit_q[n] <= writedata[7:0];
      end
      if (address == AddrCtrl) begin
        blink_q <= writedata[1];
        inv_q   <= writedata[2];
`ifdef SEG_BANK_HEX_DECODE_EN
        hex_q   <= writedata[0];
`endif
      end
      if (address == AddrMask) mask_q <= writedata[NUM_DIGITS-1:0];
      if (address == AddrDiv)  div_q  <= writedata[DIV_W-1:0];
    end
  end

  // Blink prescaler. A DIV write or a BLINK toggle restarts the phase and
  // takes priority over a coincident expiry.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (wr_en && address == AddrDiv) begin
      cnt_d   = writedata[DIV_W-1:0];
      phase_d = 1'b0;
    end else if (wr_en && address == AddrCtrl && writedata[1] != blink_q) begin
      cnt_d   = div_q;
      phase_d = 1'b0;
    end else if (blink_q && div_q != '0) begin
      if (cnt_q == '0) begin
        cnt_d   = div_q;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
    end else begin
      cnt_d   = div_q;
      phase_d = 1'b0;
    end
  end

  // Final per-digit pattern: decode, blank, then invert
  always_comb begin
    logic [7:0] pat;
    pat   = '0;
    out_d = '0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      pat = digit_q[n];
`ifdef SEG_BANK_HEX_DECODE_EN
      if (hex_q) pat = {digit_q[n][7], seg7(digit_q[n][3:0])};
`endif
      if (phase_q && mask_q[n]) pat = 8'h00;
      if (inv_q) pat = ~pat;
      out_d[8*n +: 8] = pat;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  assign out_port = out_q;

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (address == ADDR_W'(n)) readdata[7:0] = digit_q[n];
    end
    if (address == AddrCtrl) begin
      readdata[1] = blink_q;
      readdata[2] = inv_q;
`ifdef SEG_BANK_HEX_DECODE_EN
      readdata[0] = hex_q;
`endif
    end
    if (address == AddrMask) readdata[NUM_DIGITS-1:0] = mask_q;
    if (address == AddrDiv)  readdata[DIV_W-1:0]      = div_q;
  end

endmodule

// File: tb/tb_celik_lab2_sys_seg_bank.sv
// Scoreboard bench for celik_lab2_sys_seg_bank (NUM_DIGITS=6, ADDR_W=4).
// Stimulus pushes expected values; a negedge monitor pops and compares.
module tb_celik_lab2_sys_seg_bank;

`ifdef SEG_BANK_HEX_DECODE_EN
  localparam bit HexEn = 1'b1;
`else
  localparam bit HexEn = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [47:0] out_port;

  celik_lab2_sys_seg_bank #(
    .NUM_DIGITS(6),
    .ADDR_W    (4),
    .DIV_W     (24)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind 0: readdata, 1: one out_port digit, 2: whole out_port
  typedef struct {
    int          kind;
    int          idx;
    logic [47:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push(input int kind, input int idx, input logic [47:0] exp, input string name);
    chk_t e;
    e.kind = kind;
    e.idx  = idx;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    address = a;
    push(0, 0, {16'h0, exp}, name);
    tick();
  endtask

  always @(negedge clk) begin
    chk_t        e;
    logic [47:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       act = {16'h0, readdata};
        1:       act = {40'h0, out_port[8*e.idx +: 8]};
        default: act = out_port;
      endcase
      vectors++;
      if (act !== e.exp) begin
        miscompares++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
    repeat (2) @(posedge clk);
    #1;
    push(2, 0, 48'h0, "out_in_reset");
    tick();
    reset_n = 1'b1;
    push(2, 0, 48'h0, "out_after_reset");
    #1;
    vectors++;
    if (out_port !== 48'h0) begin
      miscompares++;
      $display("FAIL inline_out_after_reset: got 0x%0h expected 0x0", out_port);
    end
    for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, $sformatf("rd_reset_%0d", a));

    // Raw mode and write-to-output latency
    wr(4'd0, 32'hFFFF_FF5A);
    push(1, 0, 48'h00, "dig0_latency");
    wr(4'd5, 32'h0000_0081);
    push(1, 0, 48'h5A, "dig0_raw");
    push(1, 5, 48'h00, "dig5_latency");
    tick();
    push(1, 5, 48'h81, "dig5_raw");
    rd(4'd0, 32'h5A, "rd_dig0");
    rd(4'd5, 32'h81, "rd_dig5");
    address = 4'd0;
    #1;
    vectors++;
    if (readdata !== 32'h5A) begin
      miscompares++;
      $display("FAIL inline_rd_dig0: got 0x%0h expected 0x5a", readdata);
    end

    // Decode mode
    wr(4'd6, 32'h1);
    wr(4'd1, 32'h8A);
    push(1, 1, HexEn ? 48'h3F : 48'h00, "dig1_before");
    tick();
    push(1, 1, HexEn ? 48'hF7 : 48'h8A, "dig1_decode");
    rd(4'd6, HexEn ? 32'h1 : 32'h0, "rd_ctrl_hex");
    rd(4'd1, 32'h8A, "rd_dig1");
    wr(4'd6, 32'h0);

    // Blink: 4 visible / 4 blank
    wr(4'd8, 32'h3);
    wr(4'd7, 32'h4);
    wr(4'd2, 32'h3F);
    wr(4'd6, 32'h2);
    for (int k = 1; k <= 16; k++) begin
      tick();
      push(1, 2, (((k - 1) / 4) % 2 == 1) ? 48'h00 : 48'h3F, $sformatf("blink_%0d", k));
      push(1, 1, 48'h8A, $sformatf("blink_steady_%0d", k));
    end

    // Invert with blink, then DIV rewrite during blank phase
    wr(4'd6, 32'h0);
    wr(4'd6, 32'h6);
    for (int k = 1; k <= 6; k++) begin
      tick();
      push(1, 2, (k <= 4) ? 48'hC0 : 48'hFF, $sformatf("inv_blink_%0d", k));
      push(1, 0, 48'hA5, $sformatf("inv_steady_%0d", k));
    end
    wr(4'd8, 32'h3);
    push(1, 2, 48'hFF, "div_rewrite_edge");
    for (int k = 1; k <= 5; k++) begin
      tick();
      push(1, 2, (k <= 4) ? 48'hC0 : 48'hFF, $sformatf("div_restart_%0d", k));
    end

    // Unmapped write
    wr(4'd15, 32'hFFFF_FFFF);
    address = 4'd15;
    #1;
    vectors++;
    if (readdata !== 32'h0) begin
      miscompares++;
      $display("FAIL inline_rd_unmapped: got 0x%0h expected 0x0", readdata);
    end
    rd(4'd15, 32'h0,  "rd_unmapped");
    rd(4'd9,  32'h0,  "rd_unmapped9");
    rd(4'd0,  32'h5A, "rd_dig0_kept");
    rd(4'd2,  32'h3F, "rd_dig2_kept");
    rd(4'd6,  32'h6,  "rd_ctrl_kept");
    rd(4'd7,  32'h4,  "rd_mask_kept");
    rd(4'd8,  32'h3,  "rd_div_kept");

    // Reset mid-blink
    reset_n = 1'b0;
    #1;
    push(2, 0, 48'h0, "out_mid_reset");
    rd(4'd6, 32'h0, "rd_ctrl_mid_reset");
    reset_n = 1'b1;
    push(2, 0, 48'h0, "out_post_reset");
    for (int a = 0; a < 9; a++) rd(4'(a), 32'h0, $sformatf("rd_post_reset_%0d", a));
    tick();
    push(2, 0, 48'h0, "out_post_reset_idle");
    #1;
    vectors++;
    if (out_port !== 48'h0) begin
      miscompares++;
      $display("FAIL inline_out_post_reset: got 0x%0h expected 0x0", out_port);
    end
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/celik_lab2_sys_seg_bank.md
# celik_lab2_sys_seg_bank

Avalon-MM slave that drives a bank of seven-segment digits. It is the parametrised successor to the single 8-bit SEG PIO and lives in the same Qsys system. It holds one register per digit and offers an optional hex-nibble decode, per-digit blinking from a programmable prescaler, and output polarity control. Its `out_port` connects straight to the board HEX pins.

## Interface
- `NUM_DIGITS`, 6: number of digits, legal range 1..13.
- `ADDR_W`, 4: Avalon word-address width. Must satisfy NUM_DIGITS+3 ≤ 2**ADDR_W.
- `DIV_W`, 24: width of the blink prescaler.

Ports. Clock is `clk`; reset is `reset_n`, asynchronous and active-low.
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `address`  in  ADDR_W  word address
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  read data, combinational, zero wait states
- `out_port`  out  8*NUM_DIGITS  segment outputs; digit n occupies bits [8n+7:8n], bit order dp,g,f,e,d,c,b,a

## Operation
- A write occurs when chipselect=1 and write_n=0, sampled on the rising edge of clk.
- Register map (word addresses):
  - 0..NUM_DIGITS-1, DIGITn: 8-bit value.
  - NUM_DIGITS, CTRL:
    - bit0 HEX: decode mode.
    - bit1 BLINK: blink enable.
    - bit2 INV: invert all outputs.
  - NUM_DIGITS+1, MASK: NUM_DIGITS bits; bit n=1 makes digit n blink.
  - NUM_DIGITS+2, DIV: DIV_W-bit prescaler reload value.
- Register widths:
  - Unused writedata bits are ignored.
  - Unused readdata bits read 0.
  - Unmapped addresses read 0, and writes to them are ignored.
- Segment pattern per digit:
  - HEX=0: the pattern is DIGITn[7:0] unchanged.
  - HEX=1: the pattern is {DIGITn[7], seg(DIGITn[3:0])}.
    - seg uses the standard gfedcba encoding: 0→0x3F, 1→0x06, 8→0x7F, A→0x77, F→0x71.
    - DIGITn[6:4] is ignored.
- Blink prescaler:
  - A down-counter `cnt` runs while BLINK=1 and DIV≠0.
  - When cnt=0 it reloads DIV and toggles `phase`.
  - Otherwise it decrements by 1.
  - One phase therefore lasts DIV+1 cycles.
- Phase meaning:
  - phase=0 means visible.
  - phase=1 blanks every digit whose MASK bit is set, forcing its pattern to 0x00.
- When BLINK=0 or DIV=0, cnt holds DIV and phase is 0.
- INV=1 bitwise-inverts the final pattern, including blanked digits, which then output 0xFF.
- `out_port` is a register loaded every cycle from the final pattern.

## Timing
- Reset values:
  - All DIGITn, CTRL, MASK and DIV are 0.
  - cnt=0 and phase=0.
  - out_port is all zeros.
  - readdata is 0 for every address.
- Read latency is 0: readdata is a combinational function of address and the registers.
- Write-to-output latency:
  - A write sampled at edge E updates its register at E.
  - out_port reflects the change after edge E+1.
- Writes to DIV, or to CTRL with BLINK changing, reload cnt with the new DIV and clear phase at the same edge.
  - If this coincides with cnt expiry, the write wins and there is no toggle.
- MASK changes take effect on the next out_port update and do not disturb cnt or phase.
- If reset_n is asserted mid-blink, all state returns to its reset values immediately, asynchronously.

## Configuration
- `SEG_BANK_HEX_DECODE_EN` defined:
  - The hex decoder and CTRL.HEX are implemented as described above.
- Macro not defined:
  - No decoder is built.
  - CTRL bit0 is write-ignored and reads 0.
  - Every digit always uses its raw DIGITn pattern.

## Test plan
- Reset, then read all addresses → readdata=0 everywhere and out_port=0.
- Raw mode: write DIGIT0=0x5A and DIGIT5=0x81 → out_port[7:0]=0x5A and out_port[47:40]=0x81, two edges after the write. Read DIGIT0 back → 0x5A.
- Decode (macro on): CTRL=0x1, DIGIT1=0x8A → out_port[15:8]=0xF7. With the macro off, CTRL reads 0x0 and out_port[15:8]=0x8A.
- Blink: DIV=3, MASK=0x04, DIGIT2=0x3F, CTRL=0x2 → out_port[23:16] is 0x3F for 4 cycles, then 0x00 for 4 cycles, repeating. Other digits are steady.
- Invert with blink: CTRL=0x6, same setup → digit 2 alternates 0xC0 and 0xFF. Rewriting DIV=3 during the blank phase restores visible on the next out_port update.
- Unmapped and reset mid-run: write to address 15 → no register changes and the read returns 0. Pulse reset_n low during blink → out_port=0 while reset is asserted, and every register reads 0 afterwards.
